// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state type and sign helpers for the sequential divider.
package seq_div_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] value, input logic cond);
    return cond ? -value : value;
  endfunction
  // value must be sign-extended to MAX_W by the caller when is_signed is set
  function automatic logic [MAX_W-1:0] abs_if_signed(input logic [MAX_W-1:0] value, input logic is_signed);
    return neg_if(value, is_signed & value[MAX_W-1]);
  endfunction
endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring-division step (shift in a bit, subtract-and-test).
module seq_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q_bit
);
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh = {rem, din};
    diff = sh - {1'b0, divisor};
    q_bit = ~diff[WIDTH];
    rem_nx = q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_div.sv
// seq_div: iterative signed/unsigned restoring divider; SEQ_DIV_EARLY_OUT_EN skips CALC for trivial cases.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_zero,
  output logic             out_overflow,
  output logic             busy
);
  div_state_e state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, a_dvd, a_dvs, step_rem;
  logic neg_q, neg_r, div_zero, ovf, dz_in, ovf_in, early, step_q, accept, take;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  assign take = out_valid && out_ready;
  always_comb begin
    a_dvd = WIDTH'(abs_if_signed(in_signed ? MAX_W'($signed(in_dividend)) : MAX_W'(in_dividend), in_signed));
    a_dvs = WIDTH'(abs_if_signed(in_signed ? MAX_W'($signed(in_divisor)) : MAX_W'(in_divisor), in_signed));
    dz_in = in_divisor == '0;
    ovf_in = in_signed && in_dividend == {1'b1, {(WIDTH-1){1'b0}}} && &in_divisor;
`ifdef SEQ_DIV_EARLY_OUT_EN
    early = dz_in || ovf_in || a_dvd < a_dvs;
`else
    early = 1'b0;
`endif
  end
  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .din     (quo[WIDTH-1]),
    .divisor (dvs),
    .rem_nx  (step_rem),
    .q_bit   (step_q)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? (early ? FIX : CALC) : IDLE;
      CALC: state_nx = cnt == CNT_W'(WIDTH - 1) ? FIX : CALC;
      FIX:  state_nx = DONE;
      DONE: state_nx = take ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // quo holds the dividend bits still to be shifted in, then accumulates quotient bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div_zero <= 1'b0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
      out_quotient <= '0;
      out_remainder <= '0;
      out_div_zero <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      out_valid <= state == DONE && !take;
      case (state)
        IDLE: if (accept) begin
          cnt <= '0;
          dvs <= a_dvs;
          quo <= early ? (ovf_in ? a_dvd : '0) : a_dvd;
          rem <= early && !ovf_in ? a_dvd : '0;
          neg_q <= (in_signed & in_dividend[WIDTH-1]) ^ (in_signed & in_divisor[WIDTH-1]);
          neg_r <= in_signed & in_dividend[WIDTH-1];
          div_zero <= dz_in;
          ovf <= ovf_in;
        end
        CALC: begin
          rem <= step_rem;
          quo <= {quo[WIDTH-2:0], step_q};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          out_quotient <= div_zero ? '1 : WIDTH'(neg_if(MAX_W'(quo), neg_q));
          out_remainder <= WIDTH'(neg_if(MAX_W'(rem), neg_r));
          out_div_zero <= div_zero;
          out_overflow <= ovf;
        end
        DONE: if (take) begin
          out_div_zero <= 1'b0;
          out_overflow <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Iterative restoring divider for integer division and remainder, for signed and unsigned operands.
- Computes WIDTH-bit quotient and remainder with SystemVerilog '/' and '%' semantics: truncation toward zero; remainder sign follows the dividend.
- Division by zero and signed overflow give defined results.
- Sits behind a valid/ready request port and a valid/ready response port. Used wherever sized, typed division is needed without a combinational divider.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_signed  in  1  1 = operands are two's complement; 0 = unsigned
- in_dividend  in  WIDTH  dividend
- in_divisor  in  WIDTH  divisor
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  result consumed when out_valid && out_ready
- out_quotient  out  WIDTH  quotient
- out_remainder  out  WIDTH  remainder
- out_div_zero  out  1  divisor was zero
- out_overflow  out  1  signed most-negative / -1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by the source):
  - state=IDLE, counter=0.
  - All data outputs 0; out_valid=0, out_div_zero=0, out_overflow=0, busy=0.
  - in_ready=1 one cycle after reset release.
- Reset asserted mid-operation: the in-flight result is discarded, no out_valid pulse, return to IDLE.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1.
  - On accept, latch the sign flags and |dividend|, |divisor|. Absolute value is taken only when in_signed=1.
  - Latch the div_zero and overflow flags.
  - Go to CALC, counter=0.
- CALC: one restoring step per cycle, MSB first. Partial remainder is WIDTH+1 bits (subtract-and-test).
  - counter increments each cycle.
  - Go to FIX after WIDTH steps.
- FIX: apply signs.
  - Quotient is negated when sign(dividend) XOR sign(divisor).
  - Remainder is negated when the dividend is negative.
  - Go to DONE.
- DONE: out_valid=1; outputs stable.
  - On out_ready go to IDLE. out_valid drops on the next edge.
- Latency: accept on edge E, out_valid high after edge E+WIDTH+2.
- Throughput: no new accept until back in IDLE (in_ready=0 in CALC, FIX and DONE).
- Divisor zero: quotient = all ones, remainder = dividend (unmodified), out_div_zero=1. Result is the same for signed and unsigned. Full latency still applies.
- Signed overflow (dividend = 1<<(WIDTH-1), divisor = all ones, in_signed=1): quotient = dividend, remainder=0, out_overflow=1.
- Flags are valid only with out_valid and are cleared when leaving DONE.
- Unsigned mode ignores the MSB sign; all-ones operands are legal.

Optional Feature:
- Macro: SEQ_DIV_EARLY_OUT_EN.
- When defined, IDLE goes directly to FIX, skipping CALC, in these cases:
  - divisor zero;
  - signed overflow;
  - |dividend| < |divisor|. Here quotient=0 and the remainder is the dividend magnitude before the sign fix.
- Early-out latency: out_valid high after edge E+2.
- When undefined, every request takes WIDTH+2 cycles.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package seq_div_pkg:
  - typedef enum logic [1:0] div_state_e {IDLE, CALC, FIX, DONE};
  - function abs_if_signed(value, is_signed);
  - function neg_if(value, cond).
- Sub-module seq_div_step: one combinational restoring step. Inputs are partial remainder, next dividend bit and divisor; outputs are the new remainder and the quotient bit. Instantiated once.

Test Plan:
- Signed, WIDTH=32: -12 / 3 -> quotient -4 (0xFFFFFFFC), remainder 0; out_valid exactly 34 cycles after accept.
- Unsigned, WIDTH=32: 0xFFFFFFF4 / 3 -> quotient 1431655761, remainder 1.
- Signed, WIDTH=4: 4'b1100 / 3 -> quotient 4'b1111 (-1), remainder 4'b1111 (-1); then 7 / -2 -> quotient -3, remainder 1.
- Divisor 0, dividend 25, both modes -> quotient all ones, remainder 25, out_div_zero=1. Signed 0x80000000 / -1 -> quotient 0x80000000, remainder 0, out_overflow=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0; accept occurs only after the out_ready handshake.
  - Back-to-back requests each complete in order.
- rst_n pulsed low in mid-CALC: outputs 0 immediately, no out_valid, next request 100/7 -> quotient 14, remainder 2. With SEQ_DIV_EARLY_OUT_EN, 5/9 -> quotient 0, remainder 5, out_valid after edge E+2.
